// File: rtl/axi_llc_sram_arb.sv
// rtl/axi_llc_sram_arb.sv - round-robin SRAM port arbiter with scrub trigger and ECC error counters
module axi_llc_sram_arb #(
    parameter int unsigned  NumReq        = 2,
    parameter int unsigned  AddrWidth     = 10,
    parameter int unsigned  DataWidth     = 128,
    parameter int unsigned  NumBanks      = 1,
    parameter int unsigned  ScrubInterval = 1024,
    localparam int unsigned BeWidth       = DataWidth / 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NumReq-1:0]                  req_i,
    input  logic [NumReq-1:0]                  we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]                  gnt_o,
    output logic [NumReq-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]               rdata_o,
    output logic                               sram_req_o,
    output logic                               sram_we_o,
    output logic [AddrWidth-1:0]               sram_addr_o,
    output logic [DataWidth-1:0]               sram_wdata_o,
    output logic [BeWidth-1:0]                 sram_be_o,
    input  logic                               sram_gnt_i,
    input  logic [DataWidth-1:0]               sram_rdata_i,
    output logic [NumBanks-1:0]                scrub_trigger_o,
    input  logic [NumBanks-1:0]                single_error_i,
    input  logic [NumBanks-1:0]                multi_error_i,
    output logic [15:0]                        err_single_cnt_o,
    output logic [15:0]                        err_multi_cnt_o,
    input  logic                               err_clear_i
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxW-1:0]   rr_q, rr_d;
    logic [IdxW-1:0]   winner;
    logic [IdxW:0]     cand_sum;
    logic              found;
    logic              handshake;
    logic [NumReq-1:0] rvalid_q, rvalid_d;
    logic [15:0]       err_single_cnt_q, err_single_cnt_d;
    logic [15:0]       err_multi_cnt_q, err_multi_cnt_d;

    // First requester at or after rr_q, with wrap-around.
    always_comb begin
        winner   = rr_q;
        found    = 1'b0;
        cand_sum = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand_sum = {1'b0, rr_q} + (IdxW+1)'(k);
            if (cand_sum >= (IdxW+1)'(NumReq)) begin
                cand_sum = cand_sum - (IdxW+1)'(NumReq);
            end
            if (!found && req_i[cand_sum[IdxW-1:0]]) begin
                found  = 1'b1;
                winner = cand_sum[IdxW-1:0];
            end
        end
    end

    assign sram_req_o   = |req_i;
    assign sram_we_o    = we_i[winner];
    assign sram_addr_o  = addr_i[winner];
    assign sram_wdata_o = wdata_i[winner];
    assign sram_be_o    = be_i[winner];
    assign handshake    = sram_req_o & sram_gnt_i;
    assign rdata_o      = sram_rdata_i;
    assign rvalid_o     = rvalid_q;

    always_comb begin
        gnt_o    = '0;
        rr_d     = rr_q;
        rvalid_d = '0;
        if (handshake) begin
            gnt_o[winner] = 1'b1;
            rr_d          = (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
            if (!we_i[winner]) begin
                rvalid_d[winner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            rvalid_q <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Scrub requests wait for an idle cycle; expiries while pending collapse into one.
    if (ScrubInterval == 0) begin : gen_no_scrub
        assign scrub_trigger_o = '0;
    end else begin : gen_scrub
        localparam int unsigned TimerW = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
        localparam logic [TimerW-1:0] Reload = TimerW'(ScrubInterval - 1);

        logic [TimerW-1:0] timer_q, timer_d;
        logic              scrub_pend_q, scrub_pend_d;
        logic              scrub_fire;

        always_comb begin
            scrub_fire   = scrub_pend_q & ~(|req_i);
            timer_d      = (timer_q == '0) ? Reload : timer_q - 1'b1;
            scrub_pend_d = (timer_q == '0) | (scrub_pend_q & ~scrub_fire);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                timer_q      <= Reload;
                scrub_pend_q <= 1'b0;
            end else begin
                timer_q      <= timer_d;
                scrub_pend_q <= scrub_pend_d;
            end
        end

        assign scrub_trigger_o = {NumBanks{scrub_fire}};
    end

    always_comb begin
        err_single_cnt_d = err_single_cnt_q;
        err_multi_cnt_d  = err_multi_cnt_q;
        if (err_clear_i) begin
            err_single_cnt_d = '0;
            err_multi_cnt_d  = '0;
        end else begin
            if (|single_error_i && err_single_cnt_q != 16'hFFFF) begin
                err_single_cnt_d = err_single_cnt_q + 16'd1;
            end
            if (|multi_error_i && err_multi_cnt_q != 16'hFFFF) begin
                err_multi_cnt_d = err_multi_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_single_cnt_q <= '0;
            err_multi_cnt_q  <= '0;
        end else begin
            err_single_cnt_q <= err_single_cnt_d;
            err_multi_cnt_q  <= err_multi_cnt_d;
        end
    end

    assign err_single_cnt_o = err_single_cnt_q;
    assign err_multi_cnt_o  = err_multi_cnt_q;

endmodule

// File: tb/tb_axi_llc_sram_arb.sv
// tb/tb_axi_llc_sram_arb.sv - self-checking bench for axi_llc_sram_arb
module tb_axi_llc_sram_arb;

    localparam int NR = 2;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int BW = DW / 8;
    localparam int NB = 2;
    localparam int SI = 8;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [NR-1:0]             req_i, we_i;
    logic [NR-1:0][AW-1:0]     addr_i;
    logic [NR-1:0][DW-1:0]     wdata_i;
    logic [NR-1:0][BW-1:0]     be_i;
    logic [NR-1:0]             gnt_o, rvalid_o;
    logic [DW-1:0]             rdata_o;
    logic                      sram_req_o, sram_we_o;
    logic [AW-1:0]             sram_addr_o;
    logic [DW-1:0]             sram_wdata_o;
    logic [BW-1:0]             sram_be_o;
    logic                      sram_gnt_i;
    logic [DW-1:0]             sram_rdata_i;
    logic [NB-1:0]             scrub_trigger_o, single_error_i, multi_error_i;
    logic [15:0]               err_single_cnt_o, err_multi_cnt_o;
    logic                      err_clear_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    axi_llc_sram_arb #(
        .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .NumBanks(NB), .ScrubInterval(SI)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_gnt_i(sram_gnt_i),
        .sram_rdata_i(sram_rdata_i), .scrub_trigger_o(scrub_trigger_o),
        .single_error_i(single_error_i), .multi_error_i(multi_error_i),
        .err_single_cnt_o(err_single_cnt_o), .err_multi_cnt_o(err_multi_cnt_o),
        .err_clear_i(err_clear_i)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni         = 1'b0;
        req_i          = '0;
        we_i           = '0;
        addr_i         = '0;
        wdata_i        = '0;
        be_i           = '0;
        sram_gnt_i     = 1'b0;
        sram_rdata_i   = '0;
        single_error_i = '0;
        multi_error_i  = '0;
        err_clear_i    = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req_i = '0; we_i = '0; sram_gnt_i = 1'b0; err_clear_i = 1'b0;
        single_error_i = '0; multi_error_i = '0;
        #3;
        total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid_o); end
        total++; if (err_single_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_single_cnt: got %h want 0000", err_single_cnt_o); end
        total++; if (err_multi_cnt_o !== 16'h0) begin bad++; $display("FAIL reset_multi_cnt: got %h want 0000", err_multi_cnt_o); end
        total++; if (gnt_o !== 2'b00 || sram_req_o !== 1'b0) begin bad++; $display("FAIL reset_gnt: got gnt=%b req=%b want 00/0", gnt_o, sram_req_o); end
        total++; if (scrub_trigger_o !== 2'b00) begin bad++; $display("FAIL reset_scrub: got %b want 00", scrub_trigger_o); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        apply_reset();
        req_i = 2'b11; we_i = 2'b00; sram_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            total++; if (gnt_o !== exp_g[i]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_o, exp_g[i]); end
            if (i > 0) begin
                total++; if (rvalid_o !== exp_g[i-1]) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rvalid_o, exp_g[i-1]); end
            end
            tick();
        end
        req_i = 2'b00; sram_gnt_i = 1'b0;
        #3;
        total++; if (rvalid_o !== 2'b10) begin bad++; $display("FAIL rr_rvalid_last: got %b want 10", rvalid_o); end
        tick();
        total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL rr_rvalid_one_cycle: got %b want 00", rvalid_o); end
    endtask

    task automatic test_stall();
        apply_reset();
        req_i = 2'b10; we_i = 2'b00; sram_gnt_i = 1'b0;
        addr_i[1] = 10'h2A5;
        for (int i = 0; i < 3; i++) begin
            #3;
            total++; if (gnt_o !== 2'b00) begin bad++; $display("FAIL stall_gnt[%0d]: got %b want 00", i, gnt_o); end
            total++; if (sram_req_o !== 1'b1 || sram_addr_o !== 10'h2A5) begin bad++; $display("FAIL stall_sram[%0d]: got req=%b addr=%h want 1/2a5", i, sram_req_o, sram_addr_o); end
            tick();
        end
        sram_gnt_i = 1'b1;
        #3;
        total++; if (gnt_o !== 2'b10) begin bad++; $display("FAIL stall_gnt_final: got %b want 10", gnt_o); end
        tick();
        req_i = 2'b11;
        #3;
        total++; if (gnt_o !== 2'b01) begin bad++; $display("FAIL stall_rr_wrap: got %b want 01", gnt_o); end
        req_i = 2'b00; sram_gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_write_and_reset();
        apply_reset();
        req_i = 2'b01; we_i = 2'b01; sram_gnt_i = 1'b1;
        #3;
        total++; if (gnt_o !== 2'b01 || sram_we_o !== 1'b1) begin bad++; $display("FAIL wr_gnt: got gnt=%b we=%b want 01/1", gnt_o, sram_we_o); end
        tick();
        req_i = 2'b00; we_i = 2'b00;
        #3;
        total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL wr_no_rvalid: got %b want 00", rvalid_o); end
        req_i = 2'b01;
        tick();
        req_i = 2'b00;
        total++; if (rvalid_o !== 2'b01) begin bad++; $display("FAIL rd_rvalid: got %b want 01", rvalid_o); end
        rst_ni = 1'b0;
        #1;
        total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL rst_rvalid_async: got %b want 00", rvalid_o); end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            total++; if (rvalid_o !== 2'b00) begin bad++; $display("FAIL rst_rvalid_after[%0d]: got %b want 00", i, rvalid_o); end
            tick();
        end
        sram_gnt_i = 1'b0;
    endtask

    task automatic test_random();
        int            rr = 0;
        logic [NR-1:0] exp_rv = '0;
        apply_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            int            w;
            bit            any;
            logic [NR-1:0] exp_g;
            req_i        = NR'($urandom);
            we_i         = NR'($urandom);
            sram_gnt_i   = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < NR; r++) begin
                addr_i[r]  = AW'($urandom);
                wdata_i[r] = {$urandom, $urandom, $urandom, $urandom};
                be_i[r]    = BW'($urandom);
            end
            sram_rdata_i = {$urandom, $urandom, $urandom, $urandom};
            #3;
            any = 0; w = rr;
            for (int k = 0; k < NR; k++) begin
                int c = (rr + k) % NR;
                if (!any && req_i[c]) begin any = 1; w = c; end
            end
            exp_g = (any && sram_gnt_i) ? NR'(1 << w) : '0;
            total++; if (gnt_o !== exp_g) begin bad++; $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, gnt_o, exp_g); end
            total++; if (rvalid_o !== exp_rv) begin bad++; $display("FAIL rand_rvalid[%0d]: got %b want %b", cyc, rvalid_o, exp_rv); end
            total++; if (sram_req_o !== any) begin bad++; $display("FAIL rand_sram_req[%0d]: got %b want %b", cyc, sram_req_o, any); end
            total++; if (rdata_o !== sram_rdata_i) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", cyc, rdata_o, sram_rdata_i); end
            if (any) begin
                total++;
                if (sram_we_o !== we_i[w] || sram_addr_o !== addr_i[w] || sram_wdata_o !== wdata_i[w] || sram_be_o !== be_i[w]) begin
                    bad++;
                    $display("FAIL rand_mux[%0d]: got we=%b addr=%h be=%h want we=%b addr=%h be=%h", cyc, sram_we_o, sram_addr_o, sram_be_o, we_i[w], addr_i[w], be_i[w]);
                end
            end
            if (any && sram_gnt_i) begin
                exp_rv = we_i[w] ? '0 : NR'(1 << w);
                rr     = (w + 1) % NR;
            end else begin
                exp_rv = '0;
            end
            tick();
        end
        req_i = '0; sram_gnt_i = 1'b0;
        tick();
    endtask

    task automatic test_scrub();
        apply_reset();
        req_i = 2'b01; we_i = 2'b01; sram_gnt_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #3;
            total++; if (scrub_trigger_o !== 2'b00) begin bad++; $display("FAIL scrub_busy[%0d]: got %b want 00", i, scrub_trigger_o); end
            tick();
        end
        req_i = 2'b00;
        #3;
        total++; if (scrub_trigger_o !== 2'b11) begin bad++; $display("FAIL scrub_pulse: got %b want 11", scrub_trigger_o); end
        tick();
        for (int i = 0; i < 2; i++) begin
            #3;
            total++; if (scrub_trigger_o !== 2'b00) begin bad++; $display("FAIL scrub_single[%0d]: got %b want 00", i, scrub_trigger_o); end
            tick();
        end
        we_i = 2'b00;
    endtask

    task automatic test_err_counters();
        apply_reset();
        single_error_i = 2'b01; multi_error_i = 2'b10;
        repeat (3) tick();
        total++; if (err_single_cnt_o !== 16'd3) begin bad++; $display("FAIL cnt_single_3: got %0d want 3", err_single_cnt_o); end
        total++; if (err_multi_cnt_o !== 16'd3) begin bad++; $display("FAIL cnt_multi_3: got %0d want 3", err_multi_cnt_o); end
        err_clear_i = 1'b1;
        tick();
        err_clear_i = 1'b0;
        total++; if (err_single_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_clear_prio: got %0d want 0", err_single_cnt_o); end
        total++; if (err_multi_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_multi_clear: got %0d want 0", err_multi_cnt_o); end
        single_error_i = 2'b00; multi_error_i = 2'b00;
        repeat (2) tick();
        total++; if (err_single_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_idle: got %0d want 0", err_single_cnt_o); end
        single_error_i = 2'b10;
        repeat (65534) @(posedge clk_i);
        #1;
        total++; if (err_single_cnt_o !== 16'hFFFE) begin bad++; $display("FAIL cnt_fffe: got %h want fffe", err_single_cnt_o); end
        repeat (3) tick();
        total++; if (err_single_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate: got %h want ffff", err_single_cnt_o); end
        total++; if (err_multi_cnt_o !== 16'd0) begin bad++; $display("FAIL cnt_multi_quiet: got %h want 0000", err_multi_cnt_o); end
        single_error_i = 2'b00;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_write_and_reset();
        test_random();
        test_scrub();
        test_err_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
